// File: rtl/axi_bram_if.sv
// AXI4 memory-mapped bus bundle for axi_bram: write address, write data,
// write response, read address and read data channels.
interface axi_bram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   s_awaddr;
    logic [7:0]          s_awlen;
    logic [2:0]          s_awsize;
    logic [1:0]          s_awburst;
    logic                s_awvalid;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wlast;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [ADDR_W-1:0]   s_araddr;
    logic [7:0]          s_arlen;
    logic [2:0]          s_arsize;
    logic [1:0]          s_arburst;
    logic                s_arvalid;
    logic                s_arready;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    logic                s_rvalid;
    logic                s_rready;

    modport slave (
        input  s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bresp, s_bvalid,
        input  s_bready,
        input  s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        output s_arready,
        output s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bresp, s_bvalid,
        output s_bready,
        output s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        input  s_arready,
        input  s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );
endinterface

// File: rtl/axi_bram.sv
// AXI4 slave backed by a dual-port word array with independent read and
// write burst engines supporting FIXED, INCR and WRAP bursts.
//
// state   | meaning
// W_IDLE  | waiting for a write address
// W_DATA  | accepting write beats until the beat counter reaches len
// W_RESP  | presenting the accumulated write response
// R_IDLE  | waiting for a read address
// R_FETCH | reading the current beat's word into the output register
// R_DATA  | presenting a read beat until accepted
module axi_bram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    axi_bram_if.slave  s
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0] MEM_BYTES = AW1'(DEPTH * BYTES);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic cfg_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (int'(size) > OFF_W) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] step, win_mask, stepped;
        step     = ADDR_W'(1) << size;
        win_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        stepped  = addr + step;
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~win_mask) | (stepped & win_mask);
            default: return stepped;
        endcase
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} >= MEM_BYTES;
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Ready outputs stay low until the first clock edge after reset release.
    logic run;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run <= 1'b0;
        else       run <= 1'b1;
    end

    // ---------------- write engine ----------------
    w_state_t          w_state, w_next;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst, w_resp, w_beat_resp;
    logic              w_bad, aw_hs, w_hs, w_is_last, w_last_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        s.s_awready = 1'b0;
        s.s_wready  = 1'b0;
        s.s_bvalid  = 1'b0;
        s.s_bresp   = OKAY;
        case (w_state)
            W_IDLE: begin
                s.s_awready = run;
                if (run && s.s_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                s.s_wready = 1'b1;
                if (s.s_wvalid && w_is_last) w_next = W_RESP;
            end
            W_RESP: begin
                s.s_bvalid = 1'b1;
                s.s_bresp  = w_resp;
                if (s.s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs       = s.s_awvalid && s.s_awready;
    assign w_hs        = s.s_wvalid && (w_state == W_DATA);
    assign w_is_last   = (w_cnt == w_len);
    assign w_last_bad  = (s.s_wlast != w_is_last);
    assign w_beat_resp = w_bad ? SLVERR : (out_of_range(w_addr) ? DECERR : OKAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_cnt   <= '0;
            w_resp  <= OKAY;
        end else if (aw_hs) begin
            w_addr  <= s.s_awaddr;
            w_len   <= s.s_awlen;
            w_size  <= s.s_awsize;
            w_burst <= s.s_awburst;
            w_bad   <= cfg_bad(s.s_awlen, s.s_awsize, s.s_awburst);
            w_cnt   <= '0;
            w_resp  <= OKAY;
        end else if (w_hs) begin
            w_addr  <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt   <= w_cnt + 8'd1;
            w_resp  <= resp_max(resp_max(w_resp, w_beat_resp), w_last_bad ? SLVERR : OKAY);
        end
    end

    // Memory contents survive reset; only the write port's state machine is cleared.
    always_ff @(posedge clk) begin
        if (w_hs && (w_beat_resp == OKAY)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s.s_wstrb[b]) mem[w_addr[OFF_W +: IDX_W]][8*b +: 8] <= s.s_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst, r_resp;
    logic              r_bad, r_last, ar_hs;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        s.s_arready = 1'b0;
        s.s_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s.s_arready = run;
                if (run && s.s_arvalid) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_DATA;
            R_DATA: begin
                s.s_rvalid = 1'b1;
                if (s.s_rready) r_next = r_last ? R_IDLE : R_FETCH;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs     = s.s_arvalid && s.s_arready;
    assign s.s_rdata = r_data;
    assign s.s_rresp = r_resp;
    assign s.s_rlast = r_last;

    // The array read shares an edge with any write, so a colliding read sees the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_resp  <= OKAY;
            r_last  <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_addr  <= s.s_araddr;
                r_len   <= s.s_arlen;
                r_size  <= s.s_arsize;
                r_burst <= s.s_arburst;
                r_bad   <= cfg_bad(s.s_arlen, s.s_arsize, s.s_arburst);
                r_cnt   <= '0;
            end
            if (r_state == R_FETCH) begin
                r_last <= (r_cnt == r_len);
                if (r_bad) begin
                    r_resp <= SLVERR;
                    r_data <= '0;
                end else if (out_of_range(r_addr)) begin
                    r_resp <= DECERR;
                    r_data <= '0;
                end else begin
                    r_resp <= OKAY;
                    r_data <= mem[r_addr[OFF_W +: IDX_W]];
                end
            end
            if ((r_state == R_DATA) && s.s_rready && !r_last) begin
                r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi_bram.sv
// Directed plus randomized bench for axi_bram against a byte-array reference
// memory whose beat addresses and responses follow the AXI burst rules.
module tb_axi_bram;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int MEMB  = DEPTH * 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_bram_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    axi_bram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  ref_mem [MEMB];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bad_cfg(input int len, input int size, input int burst);
        return (size > 2) || (burst == 3) ||
               ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic int unsigned baddr(input int unsigned start, input int i, input int len,
                                          input int size, input int burst);
        int unsigned bytes, win, base;
        bytes = 1 << size;
        if (burst == 0) return start;
        if (burst == 2) begin
            win  = (len + 1) * bytes;
            base = start - (start % win);
            return base + ((start - base + i * bytes) % win);
        end
        return start + i * bytes;
    endfunction

    function automatic logic [1:0] beat_resp(input int unsigned a, input logic bad);
        if (bad) return 2'b10;
        if (a >= MEMB) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned a);
        int unsigned w;
        w = (a / 4) * 4;
        return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    endfunction

    task automatic do_write(input string tag, input int unsigned addr, input int len,
                            input int size, input int burst, input int bad_last);
        logic bad, wl;
        logic [1:0] er, br;
        int unsigned a;
        int n;
        bad = bad_cfg(len, size, burst);
        er  = 2'b00;
        for (int i = 0; i <= len; i++) begin
            a  = baddr(addr, i, len, size, burst);
            br = beat_resp(a, bad);
            if (br == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[(a / 4) * 4 + b] = wd[i][8*b +: 8];
            if (br > er) er = br;
            wl = (bad_last < 0) ? (i == len) : (i == bad_last);
            if (wl != (i == len) && er < 2'b10) er = 2'b10;
        end
        @(negedge clk);
        bus.s_awaddr  = addr;
        bus.s_awlen   = 8'(len);
        bus.s_awsize  = 3'(size);
        bus.s_awburst = 2'(burst);
        bus.s_awvalid = 1'b1;
        n = 0;
        while (bus.s_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check({tag, " aw_timeout"}, n < 100, 1);
        @(negedge clk);
        bus.s_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.s_wdata  = wd[i];
            bus.s_wstrb  = ws[i];
            bus.s_wlast  = (bad_last < 0) ? (i == len) : (i == bad_last);
            bus.s_wvalid = 1'b1;
            n = 0;
            while (bus.s_wready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) check({tag, " w_timeout"}, 0, 1);
            @(negedge clk);
        end
        bus.s_wvalid = 1'b0;
        bus.s_wlast  = 1'b0;
        bus.s_bready = 1'b1;
        n = 0;
        while (bus.s_bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check({tag, " bresp"}, bus.s_bresp, er);
        @(negedge clk);
        bus.s_bready = 1'b0;
        check({tag, " awready_after_b"}, bus.s_awready, 1);
    endtask

    task automatic do_read(input string tag, input int unsigned addr, input int len,
                           input int size, input int burst, input int stall);
        logic bad;
        logic [1:0] er;
        logic [31:0] ed, held;
        int unsigned a;
        int n;
        bad = bad_cfg(len, size, burst);
        @(negedge clk);
        bus.s_araddr  = addr;
        bus.s_arlen   = 8'(len);
        bus.s_arsize  = 3'(size);
        bus.s_arburst = 2'(burst);
        bus.s_arvalid = 1'b1;
        n = 0;
        while (bus.s_arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check({tag, " ar_timeout"}, n < 100, 1);
        @(negedge clk);
        bus.s_arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a  = baddr(addr, i, len, size, burst);
            er = beat_resp(a, bad);
            ed = (er == 2'b00) ? ref_word(a) : 32'h0;
            n = 0;
            while (bus.s_rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            // Two cycles from the AR or R handshake edge to the next valid beat.
            check({tag, " beat_spacing"}, n, 1);
            if (i == 0) begin
                held = bus.s_rdata;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    check({tag, " stall_rvalid"}, bus.s_rvalid, 1);
                    check({tag, " stall_rdata"}, bus.s_rdata, held);
                end
            end
            rd[i] = bus.s_rdata;
            check({tag, " rdata"}, bus.s_rdata, ed);
            check({tag, " rresp"}, bus.s_rresp, er);
            check({tag, " rlast"}, bus.s_rlast, (i == len));
            bus.s_rready = 1'b1;
            @(negedge clk);
            bus.s_rready = 1'b0;
        end
        check({tag, " arready_after_r"}, bus.s_arready, 1);
    endtask

    initial begin
        int unsigned addr;
        int len, size, burst, n;
        bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0; bus.s_awburst = '0;
        bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arlen = '0;
        bus.s_arsize = '0; bus.s_arburst = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;

        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst awready", bus.s_awready, 0);
        check("rst wready",  bus.s_wready, 0);
        check("rst bvalid",  bus.s_bvalid, 0);
        check("rst arready", bus.s_arready, 0);
        check("rst rvalid",  bus.s_rvalid, 0);
        check("rst bresp",   bus.s_bresp, 0);
        check("rst rresp",   bus.s_rresp, 0);
        check("rst rdata",   bus.s_rdata, 0);
        check("rst rlast",   bus.s_rlast, 0);
        reset = 1'b0;
        #1 check("release awready_before_edge", bus.s_awready, 0);
        @(negedge clk);
        check("release awready", bus.s_awready, 1);
        check("release arready", bus.s_arready, 1);

        // Fill the whole array so every later read has a known expectation.
        for (int blk = 0; blk < MEMB / 64; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write("init", blk * 64, 15, 2, 1, -1);
        end

        for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
        do_write("incr_wr", 32'h10, 3, 2, 1, -1);
        do_read("incr_rd", 32'h10, 3, 2, 1, 0);
        for (int i = 0; i < 4; i++) check("incr_rd const", rd[i], i + 1);

        do_read("wrap_rd", 32'h18, 3, 2, 2, 0);
        check("wrap beat0", rd[0], 3);
        check("wrap beat1", rd[1], 4);
        check("wrap beat2", rd[2], 1);
        check("wrap beat3", rd[3], 2);

        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write("strb_full", 32'h40, 0, 2, 1, -1);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write("strb_part", 32'h40, 0, 2, 1, -1);
        do_read("strb_rd", 32'h40, 0, 2, 1, 0);
        check("strb const", rd[0], 32'hAA22CC44);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write("decerr_wr", MEMB, 0, 2, 1, -1);
        do_read("decerr_rd", MEMB, 0, 2, 1, 0);
        do_read("decerr_alias", 0, 0, 2, 1, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write("wlast_early", 32'h80, 3, 2, 1, 1);
        do_write("wlast_missing", 32'h90, 3, 2, 1, 9);
        do_read("wlast_rd", 32'h80, 7, 2, 1, 0);

        do_write("slv_size", 32'h100, 1, 3, 1, -1);
        do_write("slv_burst", 32'h100, 1, 2, 3, -1);
        do_write("slv_wraplen", 32'h100, 2, 2, 2, -1);
        do_read("slv_rd_size", 32'h100, 1, 3, 1, 0);
        do_read("slv_rd_wraplen", 32'h100, 2, 2, 2, 0);
        do_read("slv_check_mem", 32'h100, 3, 2, 1, 0);

        do_read("stall_rd", 32'h10, 1, 2, 1, 5);

        for (int t = 0; t < 30; t++) begin
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            if (burst == 2) begin
                case ($urandom_range(0, 4))
                    0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15; default: len = 2;
                endcase
            end else len = $urandom_range(0, 15);
            addr = ($urandom_range(0, 7) == 0) ? $urandom_range(MEMB - 120, MEMB + 100)
                                               : $urandom_range(0, MEMB - 1);
            addr = (addr >> size) << size;
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write("rand_wr", addr, len, size, burst, -1);
            do_read("rand_rd", addr, len, size, burst, 0);
        end

        // Reset in the middle of a write burst: two beats land, the rest is abandoned.
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        @(negedge clk);
        bus.s_awaddr = 32'h200; bus.s_awlen = 8'd3; bus.s_awsize = 3'd2; bus.s_awburst = 2'd1;
        bus.s_awvalid = 1'b1;
        n = 0;
        while (bus.s_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("midrst aw_timeout", n < 100, 1);
        @(negedge clk);
        bus.s_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.s_wdata = wd[i]; bus.s_wstrb = 4'hF; bus.s_wlast = 1'b0; bus.s_wvalid = 1'b1;
            n = 0;
            while (bus.s_wready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) check("midrst w_timeout", 0, 1);
            @(negedge clk);
            for (int b = 0; b < 4; b++) ref_mem[32'h200 + 4 * i + b] = wd[i][8*b +: 8];
        end
        bus.s_wvalid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst awready", bus.s_awready, 0);
        check("midrst wready",  bus.s_wready, 0);
        check("midrst bvalid",  bus.s_bvalid, 0);
        check("midrst arready", bus.s_arready, 0);
        check("midrst rvalid",  bus.s_rvalid, 0);
        @(negedge clk);
        reset = 1'b0;
        do_read("midrst_rd", 32'h200, 3, 2, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_bram.md
AXI_BRAM -- requirements
Module: axi_bram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width in bits (32 or 64).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning AXI address width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning memory depth in DATA_W words (power of 2).
REQ-004 The block SHALL have these ports, one per line:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high reset
s_awaddr  in  ADDR_W  write burst start byte address
s_awlen  in  8  write beats minus 1
s_awsize  in  3  log2 bytes per beat
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte-lane enables
s_wlast  in  1  final write beat
s_wvalid  in  1  W valid
s_wready  out  1  W ready
s_bresp  out  2  write response
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_araddr  in  ADDR_W  read burst start byte address
s_arlen  in  8  read beats minus 1
s_arsize  in  3  log2 bytes per beat
s_arburst  in  2  burst type
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_rlast  out  1  final read beat
s_rvalid  out  1  R valid
s_rready  in  1  R ready

Function
REQ-005 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP: W_IDLE->W_DATA on AW handshake, W_DATA->W_RESP on handshake of beat s_awlen+1, W_RESP->W_IDLE on B handshake.
REQ-006 s_awready SHALL be 1 only in W_IDLE, s_wready only in W_DATA, and s_bvalid only in W_RESP.
REQ-007 Read FSM states SHALL be R_IDLE, R_FETCH and R_DATA: R_IDLE->R_FETCH on AR handshake, R_FETCH->R_DATA after one cycle, R_DATA->R_FETCH on a non-last R handshake, and R_DATA->R_IDLE on the last R handshake.
REQ-008 s_arready SHALL be 1 only in R_IDLE; s_rvalid SHALL be 1 only in R_DATA, with s_rdata, s_rresp and s_rlast held stable until s_rready.
REQ-009 Read and write FSMs SHALL run independently on a dual-port array; a same-cycle read and write to one word SHALL return the old data.
REQ-010 Beat address SHALL be: FIXED constant; INCR +(1<<size); WRAP +(1<<size) wrapping within an aligned (len+1)<<size byte window.
REQ-011 Word index SHALL be addr>>log2(DATA_W/8); each write beat SHALL update only bytes whose s_wstrb bit is 1; each read beat SHALL return the full word.
REQ-012 A beat whose byte address is >= DEPTH*DATA_W/8 SHALL be DECERR (11): no write, rdata 0.
REQ-013 A burst with size > log2(DATA_W/8), burst type 11, or WRAP with len not in {1,3,7,15} SHALL be SLVERR (10) on every beat, with no memory write and rdata 0, while all beats are still handshaken.
REQ-014 s_bresp SHALL be the highest-coded response over all beats; it SHALL also be SLVERR if s_wlast is not exactly on beat s_awlen+1, and the beat counter alone SHALL terminate the burst.
REQ-015 Read throughput SHALL be one beat per 2 cycles with s_rready=1; latency from AR handshake to first s_rvalid SHALL be 2 cycles.

Reset
REQ-016 While reset=1: both FSMs idle; s_awready, s_wready, s_bvalid, s_arready and s_rvalid at 0; s_bresp, s_rresp, s_rdata and s_rlast at 0; ready outputs asserted from the first clk edge after deassertion; a reset mid-burst SHALL abandon the burst, keep already-written beats, and leave memory uncleared.

Verification
REQ-018 INCR write, addr 0x10, len 3, size 2, data 1..4, strb F -> bresp 00; INCR read of the same burst -> 1,2,3,4 with rlast on beat 4 and rresp 00.
REQ-019 WRAP read, addr 0x18, len 3, size 2 -> words at 0x18, 0x1C, 0x10, 0x14.
REQ-020 Write 0xAABBCCDD then strb 0101 with data 0x11223344 -> read returns 0xAA22CC44.
REQ-021 Write at DEPTH*4 -> bresp 11, memory unchanged; read there -> rdata 0, rresp 11.
REQ-022 Read len 1 with rready held low for 5 cycles -> rvalid and rdata stable; reset asserted in W_DATA -> all valids 0 immediately and earlier beats readable afterwards.
